lowpan_frame_packetiser: RTL and testbench

Parametrised successor to the single-byte IPv6 packetiser. Buffers a variable-length payload burst (valid/ready/last) into an internal FIFO, then emits one 8-byte IPv6-style header and the buffered payload to the radio, one byte per send pulse. The header carries the true payload length and a per-frame sequence number. Sits between the sensor data path and the radio TX interface.

---
 rtl/lowpan_frame_packetiser_pkg.sv | 37 +++
 rtl/lowpan_frame_packetiser_if.sv | 25 ++
 rtl/lowpan_frame_packetiser_fifo.sv | 54 +++++
 rtl/lowpan_frame_packetiser.sv | 149 ++++++++++++++
 tb/tb_lowpan_frame_packetiser.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lowpan_frame_packetiser_pkg.sv
// Shared constants, state encoding and header byte selection for the LoWPAN frame packetiser.
package lowpan_pkg;

  localparam int unsigned HDR_BYTES = 8;
  localparam logic [7:0]  HDR_B0    = 8'h60;
  localparam logic [7:0]  HDR_B1    = 8'h00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DISCARD,
    S_HEADER,
    S_PAYLOAD,
    S_DONE
  } state_e;

  // Byte idx of the 8-byte IPv6-style header.
  function automatic logic [7:0] hdr_byte(input logic [2:0]  idx,
                                          input logic [15:0] len,
                                          input logic [15:0] seq,
                                          input logic [7:0]  next_hdr,
                                          input logic [7:0]  hop_limit);
    logic [7:0] b;
    case (idx)
      3'd0:    b = HDR_B0;
      3'd1:    b = HDR_B1;
      3'd2:    b = len[15:8];
      3'd3:    b = len[7:0];
      3'd4:    b = next_hdr;
      3'd5:    b = hop_limit;
      3'd6:    b = seq[15:8];
      default: b = seq[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/lowpan_frame_packetiser_if.sv
// Payload-in / radio-out signal bundle of the LoWPAN frame packetiser.
interface lowpan_frame_packetiser_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic        abort;
  logic [7:0]  tx_data;
  logic        send;
  logic        radio_busy;
  logic        packet_valid;
  logic        frame_done;
  logic        err_trunc;
  logic [15:0] seq_num;

  modport master (
    output in_data, in_valid, in_last, abort, radio_busy,
    input  in_ready, tx_data, send, packet_valid, frame_done, err_trunc, seq_num
  );

  modport slave (
    input  in_data, in_valid, in_last, abort, radio_busy,
    output in_ready, tx_data, send, packet_valid, frame_done, err_trunc, seq_num
  );
endinterface

// File: rtl/lowpan_frame_packetiser_fifo.sv
// Synchronous show-ahead byte FIFO: rd_data always presents the oldest entry.
module pkt_byte_fifo #(
  parameter int unsigned DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [7:0]               i_wr_data,
  output logic [7:0]               o_rd_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push_ok, w_pop_ok;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;
  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array carries no reset; pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push_ok && !i_flush) r_mem[r_wr_ptr] <= i_wr_data;
  end
endmodule

// File: rtl/lowpan_frame_packetiser.sv
// Buffers one payload burst, then streams an 8-byte header plus the payload to the radio.
module lowpan_frame_packetiser #(
  parameter int unsigned MAX_PAYLOAD = 32,
  parameter logic [7:0]  NEXT_HDR    = 8'h11,
  parameter logic [7:0]  HOP_LIMIT   = 8'h40
) (
  input logic                         clk,
  input logic                         rst_n,
  lowpan_frame_packetiser_if.slave    bus
);
  import lowpan_pkg::*;

  localparam int unsigned CW = $clog2(MAX_PAYLOAD) + 1;

  state_e        r_state, w_state_nxt;
  logic [CW-1:0] r_idx, r_len, w_count;
  logic [15:0]   r_seq;
  logic [7:0]    r_tx_last, w_tx_byte, w_fifo_rd;
  logic          r_send_d, r_trunc;
  logic          w_abort, w_beat, w_push, w_pop, w_fill, w_full, w_empty;
  logic          w_in_ready, w_send, w_pkt_valid, w_frame_done, w_err_trunc;

  assign w_abort = bus.abort && (r_state != S_IDLE);
  assign w_beat  = bus.in_valid && w_in_ready;
  assign w_push  = w_beat && ((r_state == S_IDLE) || (r_state == S_LOAD));
  assign w_fill  = (w_count == CW'(MAX_PAYLOAD - 1));

  pkt_byte_fifo #(.DEPTH(MAX_PAYLOAD)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_push    (w_push),
    .i_pop     (w_pop),
    .i_flush   (w_abort),
    .i_wr_data (bus.in_data),
    .o_rd_data (w_fifo_rd),
    .o_count   (w_count),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:    if (w_beat) w_state_nxt = bus.in_last ? S_HEADER : S_LOAD;
        S_LOAD:    if (w_beat) begin
                     if (bus.in_last)  w_state_nxt = S_HEADER;
                     else if (w_fill)  w_state_nxt = S_DISCARD;
                   end
        S_DISCARD: if (w_beat && bus.in_last) w_state_nxt = S_HEADER;
        S_HEADER:  if (w_send && (r_idx == CW'(HDR_BYTES - 1))) w_state_nxt = S_PAYLOAD;
        S_PAYLOAD: if (w_send && (r_idx == r_len - CW'(1)))     w_state_nxt = S_DONE;
        S_DONE:    w_state_nxt = S_IDLE;
        default:   w_state_nxt = S_IDLE;
      endcase
    end
  end

  // send uses the live radio_busy and is spaced by at least one idle cycle.
  always_comb begin
    w_in_ready   = 1'b0;
    w_send       = 1'b0;
    w_pop        = 1'b0;
    w_pkt_valid  = 1'b0;
    w_frame_done = 1'b0;
    w_err_trunc  = 1'b0;
    w_tx_byte    = w_fifo_rd;
    case (r_state)
      S_IDLE:    w_in_ready = 1'b1;
      S_LOAD:    w_in_ready = !w_full;
      S_DISCARD: begin
        w_in_ready  = 1'b1;
        w_err_trunc = bus.in_valid && bus.in_last && r_trunc;
      end
      S_HEADER: begin
        w_send      = !bus.radio_busy && !r_send_d;
        w_pkt_valid = w_send || (r_idx != '0);
        w_tx_byte   = hdr_byte(r_idx[2:0], 16'(r_len), r_seq, NEXT_HDR, HOP_LIMIT);
      end
      S_PAYLOAD: begin
        w_send      = !bus.radio_busy && !r_send_d;
        w_pop       = w_send && !w_empty;
        w_pkt_valid = 1'b1;
      end
      S_DONE:    w_frame_done = 1'b1;
      default:   ;
    endcase
    if (w_abort) begin
      w_in_ready   = 1'b0;
      w_send       = 1'b0;
      w_pop        = 1'b0;
      w_pkt_valid  = 1'b0;
      w_frame_done = 1'b0;
      w_err_trunc  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx     <= '0;
      r_len     <= '0;
      r_seq     <= '0;
      r_tx_last <= '0;
      r_send_d  <= 1'b0;
      r_trunc   <= 1'b0;
    end else begin
      r_send_d <= w_send;
      if (w_send) r_tx_last <= w_tx_byte;
      if (w_abort) begin
        r_idx   <= '0;
        r_trunc <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_idx   <= '0;
            r_trunc <= 1'b0;
          end
          S_LOAD: if (w_beat && !bus.in_last && w_fill) r_trunc <= 1'b1;
          S_HEADER: begin
            // FIFO count is stable throughout the header, so latch it before byte 2.
            if (r_idx == '0) r_len <= w_count;
            if (w_send) r_idx <= (r_idx == CW'(HDR_BYTES - 1)) ? '0 : r_idx + CW'(1);
          end
          S_PAYLOAD: if (w_send) r_idx <= r_idx + CW'(1);
          S_DONE: begin
            r_seq   <= r_seq + 16'd1;
            r_trunc <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.in_ready     = w_in_ready;
  assign bus.send         = w_send;
  assign bus.tx_data      = w_send ? w_tx_byte : r_tx_last;
  assign bus.packet_valid = w_pkt_valid;
  assign bus.frame_done   = w_frame_done;
  assign bus.err_trunc    = w_err_trunc;
  assign bus.seq_num      = r_seq;
endmodule

// File: tb/tb_lowpan_frame_packetiser.sv
// Scoreboard bench: a frame model queues expected radio bytes, a negedge monitor consumes them.
module tb_lowpan_frame_packetiser;
  localparam int unsigned MAXP = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lowpan_frame_packetiser_if bus();

  lowpan_frame_packetiser #(.MAX_PAYLOAD(MAXP), .NEXT_HDR(8'h11), .HOP_LIMIT(8'h40)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  exp_q[$];
  logic [15:0] done_q[$];
  logic [15:0] m_seq = 16'd0;
  int          exp_trunc = 0;
  int          n_sent = 0, n_trunc = 0, n_done = 0;
  bit          rand_busy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame model: header then up to MAXP payload bytes; keep>=0 models an abort after keep payload bytes.
  task automatic push_frame(input logic [7:0] pl[$], input int keep);
    int          len;
    int          np;
    logic [15:0] l16;
    len = (pl.size() > MAXP) ? MAXP : pl.size();
    l16 = 16'(len);
    exp_q.push_back(8'h60);
    exp_q.push_back(8'h00);
    exp_q.push_back(l16[15:8]);
    exp_q.push_back(l16[7:0]);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h40);
    exp_q.push_back(m_seq[15:8]);
    exp_q.push_back(m_seq[7:0]);
    np = (keep < 0) ? len : keep;
    for (int i = 0; i < np; i++) exp_q.push_back(pl[i]);
    if (keep < 0) begin
      done_q.push_back(m_seq);
      m_seq = m_seq + 16'd1;
      if (pl.size() > MAXP) exp_trunc++;
    end
  endtask

  task automatic drive_burst(input logic [7:0] pl[$], input bit strict);
    int waited;
    for (int i = 0; i < pl.size(); i++) begin
      if (!strict && ($urandom_range(3) == 0)) begin
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = pl[i];
      bus.in_last  = (i == pl.size() - 1);
      waited = 0;
      forever begin
        @(negedge clk);
        if (bus.in_ready) break;
        waited++;
        if (waited > 3000) break;
      end
      if (waited > 3000) begin
        n_checks++; n_errors++;
        $display("FAIL in_ready_timeout: got 0 expected 1");
        bus.in_valid = 1'b0;
        return;
      end
      if (strict) check("in_ready_no_stall", 32'(waited), 32'd0);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_sent(input int target);
    int g = 0;
    while (n_sent < target && g < 3000) begin
      @(posedge clk); g++;
    end
    if (n_sent < target) begin
      n_checks++; n_errors++;
      $display("FAIL wait_sent: got %0d expected %0d", n_sent, target);
    end
    #1;
  endtask

  task automatic wait_drain();
    int g = 0;
    while ((exp_q.size() != 0 || done_q.size() != 0) && g < 5000) begin
      @(posedge clk); g++;
    end
    check("drain_bytes_left", 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Monitor: every send must match the next modelled byte.
  int          cyc = 0, last_cyc = 0;
  bit          have_prev = 0, prev_pv = 0, busy_since = 0, pend_v = 0;
  logic [15:0] pend_seq = 16'd0, e_seq;
  logic [7:0]  e_byte;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      have_prev = 0; prev_pv = 0; busy_since = 0; pend_v = 0;
    end else begin
      if (pend_v) begin
        check("seq_after_done", 32'(bus.seq_num), 32'(pend_seq));
        pend_v = 0;
      end
      if (bus.send) begin
        check("send_while_busy", 32'(bus.radio_busy), 32'd0);
        check("pv_on_send", 32'(bus.packet_valid), 32'd1);
        if (have_prev && prev_pv)
          check("send_spacing", 32'((cyc - last_cyc == 2) || (busy_since && (cyc - last_cyc > 2))), 32'd1);
        if (exp_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL unexpected_send: got %0h expected none", bus.tx_data);
        end else begin
          e_byte = exp_q.pop_front();
          check("tx_byte", 32'(bus.tx_data), 32'(e_byte));
        end
        n_sent++; last_cyc = cyc; have_prev = 1; busy_since = 0;
      end else if (bus.radio_busy) begin
        busy_since = 1;
      end
      if (bus.frame_done) begin
        n_done++;
        if (done_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL unexpected_frame_done: got seq %0h expected none", bus.seq_num);
        end else begin
          e_seq = done_q.pop_front();
          check("frame_done_seq", 32'(bus.seq_num), 32'(e_seq));
          pend_seq = e_seq + 16'd1;
          pend_v = 1;
        end
      end
      if (bus.err_trunc) n_trunc++;
      prev_pv = bus.packet_valid;
    end
  end

  always @(posedge clk) begin
    if (rand_busy) begin
      #1;
      bus.radio_busy = ($urandom_range(3) == 0);
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_send"}, 32'(bus.send), 32'd0);
    check({tag, "_pv"},   32'(bus.packet_valid), 32'd0);
    check({tag, "_done"}, 32'(bus.frame_done), 32'd0);
    check({tag, "_trunc"}, 32'(bus.err_trunc), 32'd0);
    check({tag, "_tx"},   32'(bus.tx_data), 32'd0);
    check({tag, "_seq"},  32'(bus.seq_num), 32'd0);
  endtask

  logic [7:0] pl[$];
  int         base, done_before;

  initial begin
    bus.in_data = 8'h00; bus.in_valid = 1'b0; bus.in_last = 1'b0;
    bus.abort = 1'b0; bus.radio_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 3-byte burst
    pl = '{8'hAA, 8'hBB, 8'hCC};
    push_frame(pl, -1);
    drive_burst(pl, 1'b1);
    wait_drain();
    check("seq_after_first", 32'(bus.seq_num), 32'd1);

    // single-byte frames back to back
    for (int k = 0; k < 2; k++) begin
      pl = '{8'h5A};
      push_frame(pl, -1);
      drive_burst(pl, 1'b1);
      wait_drain();
    end

    // oversize burst truncated to MAXP
    pl.delete();
    for (int i = 0; i < 40; i++) pl.push_back(8'(i + 1));
    push_frame(pl, -1);
    drive_burst(pl, 1'b1);
    wait_drain();
    check("trunc_pulses", 32'(n_trunc), 32'(exp_trunc));

    // radio busy for 10 cycles before header byte 3
    pl = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
    push_frame(pl, -1);
    base = n_sent;
    drive_burst(pl, 1'b0);
    wait_sent(base + 3);
    bus.radio_busy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("pv_held_busy", 32'(bus.packet_valid), 32'd1);
      @(posedge clk); #1;
    end
    check("busy_no_send", 32'(n_sent), 32'(base + 3));
    bus.radio_busy = 1'b0;
    wait_drain();

    // abort after 2 of 5 payload bytes
    pl = '{8'hE1, 8'hE2, 8'hE3, 8'hE4, 8'hE5};
    push_frame(pl, 2);
    base = n_sent;
    done_before = n_done;
    drive_burst(pl, 1'b0);
    wait_sent(base + 10);
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    check("abort_pv", 32'(bus.packet_valid), 32'd0);
    check("abort_seq", 32'(bus.seq_num), 32'(m_seq));
    repeat (4) @(posedge clk);
    #1;
    check("abort_no_done", 32'(n_done), 32'(done_before));
    check("abort_no_extra", 32'(n_sent), 32'(base + 10));
    pl = '{8'hD1, 8'hD2, 8'hD3, 8'hD4, 8'hD5};
    push_frame(pl, -1);
    drive_burst(pl, 1'b0);
    wait_drain();

    // reset in the middle of a header
    pl = '{8'h01, 8'h02, 8'h03, 8'h04};
    push_frame(pl, -1);
    base = n_sent;
    drive_burst(pl, 1'b0);
    wait_sent(base + 3);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_q.delete();
    done_q.delete();
    m_seq = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    pl = '{8'h77, 8'h88};
    push_frame(pl, -1);
    drive_burst(pl, 1'b0);
    wait_drain();

    // random frames against a randomly busy radio
    rand_busy = 1'b1;
    for (int f = 0; f < 10; f++) begin
      pl.delete();
      for (int i = 0; i < int'($urandom_range(40, 1)); i++) pl.push_back(8'($urandom));
      push_frame(pl, -1);
      drive_burst(pl, 1'b0);
      wait_drain();
    end
    rand_busy = 1'b0;
    @(posedge clk); #2;
    bus.radio_busy = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    check("final_trunc", 32'(n_trunc), 32'(exp_trunc));
    check("final_done_q", 32'(done_q.size()), 32'd0);
    check("final_seq", 32'(bus.seq_num), 32'(m_seq));
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
